// File: rtl/pll_lock_monitor.sv
// Frequency-based PLL lock monitor: counts DCO cycles over a reference window and flags loss of lock.
// Optional min/max count history enabled by defining PLL_LOCK_MON_HIST_EN.
`timescale 1ns/1ps

module pll_lock_monitor #(
    parameter int unsigned WIN_CYC    = 16,
    parameter int unsigned MULT       = 10,
    parameter int unsigned TOL        = 4,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned FAIL_LIMIT = 2,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dco_clk,
    input  logic             locked_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             lock_lost,
    output logic             relock_req
`ifdef PLL_LOCK_MON_HIST_EN
    ,
    output logic [CNT_W-1:0] cnt_min,
    output logic [CNT_W-1:0] cnt_max
`endif
);

    localparam int unsigned CYC_MAX  = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int unsigned CYC_W    = $clog2(CYC_MAX) + 1;
    localparam int unsigned FC_W     = 4;
    localparam int unsigned ERR_W    = CNT_W + 1;

    localparam logic [ERR_W-1:0] TARGET   = ERR_W'(MULT * WIN_CYC);
    localparam logic [ERR_W-1:0] TOL_E    = ERR_W'(TOL);
    localparam logic [FC_W-1:0]  FAIL_LIM = FC_W'(FAIL_LIMIT);
    localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN_CYC - 1);
    localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WINDOW = 3'd2,
        SETTLE = 3'd3,
        EVAL   = 3'd4
    } state_t;

    state_t             state;
    logic               win_en;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [FC_W-1:0]    fail_cnt;

    logic               win_m;
    logic               win_s;
    logic               win_d;
    logic [CNT_W-1:0]   dco_cnt;

    logic [ERR_W-1:0]   cnt_ext;
    logic [ERR_W-1:0]   err;
    logic               in_tol;
    logic [FC_W-1:0]    fail_inc;

    // Window evaluation: absolute count error and saturating fail increment
    always_comb begin
        cnt_ext  = ERR_W'(dco_cnt);
        err      = (cnt_ext > TARGET) ? (cnt_ext - TARGET) : (TARGET - cnt_ext);
        in_tol   = (err <= TOL_E);
        fail_inc = (fail_cnt >= FAIL_LIM) ? FAIL_LIM : (fail_cnt + FC_W'(1));
    end

    // Reference-domain control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_en     <= 1'b0;
            cyc_cnt    <= '0;
            fail_cnt   <= '0;
            freq_cnt   <= '0;
            meas_valid <= 1'b0;
            freq_ok    <= 1'b0;
            lock_lost  <= 1'b0;
            relock_req <= 1'b0;
`ifdef PLL_LOCK_MON_HIST_EN
            cnt_min    <= '1;
            cnt_max    <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            relock_req <= 1'b0;
            if (!locked_in) begin
                // Losing lock aborts any measurement in flight
                state     <= IDLE;
                win_en    <= 1'b0;
                cyc_cnt   <= '0;
                fail_cnt  <= '0;
                lock_lost <= 1'b0;
                freq_ok   <= 1'b0;
`ifdef PLL_LOCK_MON_HIST_EN
                cnt_min   <= '1;
                cnt_max   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM: begin
                        state   <= WINDOW;
                        win_en  <= 1'b1;
                        cyc_cnt <= '0;
                    end
                    WINDOW: begin
                        if (cyc_cnt == WIN_LAST) begin
                            state   <= SETTLE;
                            win_en  <= 1'b0;
                            cyc_cnt <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cyc_cnt == SET_LAST) begin
                            state   <= EVAL;
                            cyc_cnt <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                        end
                    end
                    EVAL: begin
                        // DCO counter is quiescent here, so it is sampled directly
                        state      <= ARM;
                        freq_cnt   <= dco_cnt;
                        freq_ok    <= in_tol;
                        meas_valid <= 1'b1;
                        if (in_tol) begin
                            fail_cnt <= '0;
                        end else begin
                            fail_cnt <= fail_inc;
                            if ((fail_inc == FAIL_LIM) && !lock_lost) begin
                                lock_lost  <= 1'b1;
                                relock_req <= 1'b1;
                            end
                        end
`ifdef PLL_LOCK_MON_HIST_EN
                        if (dco_cnt < cnt_min) cnt_min <= dco_cnt;
                        if (dco_cnt > cnt_max) cnt_max <= dco_cnt;
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // DCO domain: synchronize the window and count DCO cycles while it is open
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_m   <= 1'b0;
            win_s   <= 1'b0;
            win_d   <= 1'b0;
            dco_cnt <= '0;
        end else begin
            win_m <= win_en;
            win_s <= win_m;
            win_d <= win_s;
            if (win_s && !win_d) begin
                dco_cnt <= CNT_W'(1);
            end else if (win_s && (dco_cnt != '1)) begin
                dco_cnt <= dco_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: latency, count accuracy, fail logic, lock drop and reset with stopped DCO.
`timescale 1ns/1ps

module tb_pll_lock_monitor;

    localparam int unsigned CNT_W = 10;

    logic             clk;
    logic             rst_n;
    logic             dco_clk;
    logic             locked_in;
    logic [CNT_W-1:0] freq_cnt;
    logic             meas_valid;
    logic             freq_ok;
    logic             lock_lost;
    logic             relock_req;
`ifdef PLL_LOCK_MON_HIST_EN
    logic [CNT_W-1:0] cnt_min;
    logic [CNT_W-1:0] cnt_max;
`endif

    int      errors = 0;
    int      checks = 0;
    realtime dco_half = 1.0;
    bit      dco_run = 1'b1;

    pll_lock_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dco_clk    (dco_clk),
        .locked_in  (locked_in),
        .freq_cnt   (freq_cnt),
        .meas_valid (meas_valid),
        .freq_ok    (freq_ok),
        .lock_lost  (lock_lost),
        .relock_req (relock_req)
`ifdef PLL_LOCK_MON_HIST_EN
        ,
        .cnt_min    (cnt_min),
        .cnt_max    (cnt_max)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // DCO offset by 0.3 ns so its edges never coincide with reference edges
    initial begin
        dco_clk = 1'b0;
        #0.3;
        forever begin
            if (dco_run) #(dco_half) dco_clk = ~dco_clk;
            else #0.5;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until meas_valid is seen; n is the number of edges taken (60 on timeout)
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!meas_valid && n < 60);
    endtask

    function automatic logic [31:0] in_rng(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return 32'((int'(v) >= lo) && (int'(v) <= hi));
    endfunction

    initial begin
        int n;
        bit seen;
        rst_n     = 1'b0;
        locked_in = 1'b0;
        repeat (3) tick();
        check("rst_freq_cnt",   32'(freq_cnt),   0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_freq_ok",    32'(freq_ok),    0);
        check("rst_lock_lost",  32'(lock_lost),  0);
        check("rst_relock_req", 32'(relock_req), 0);

        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_valid", 32'(meas_valid), 0);

        // Exact 10x ratio: 160 counts, 22-cycle latency and period
        locked_in = 1'b1;
        tick();
        wait_valid(n);
        check("first_latency", 32'(n), 22);
        check("cnt_10x",       32'(freq_cnt), 160);
        check("ok_10x",        32'(freq_ok), 1);
        check("lost_10x",      32'(lock_lost), 0);
        wait_valid(n);
        check("period",        32'(n), 22);
        check("cnt_10x_b",     32'(freq_cnt), 160);

        // 10.2x: about 163.3 counts, within tolerance
        dco_half = 0.980;
        tick();
        check("valid_pulse", 32'(meas_valid), 0);
        wait_valid(n);
        check("period_after_pulse", 32'(n), 21);
        check("cnt_10p2_rng", in_rng(freq_cnt, 163, 164), 1);
        check("ok_10p2",      32'(freq_ok), 1);

        // 10.5x: about 168 counts, out of tolerance; first fail
        dco_half = 0.952;
        wait_valid(n);
        check("cnt_10p5_rng", in_rng(freq_cnt, 168, 169), 1);
        check("ok_10p5",      32'(freq_ok), 0);
        check("lost_fail1",   32'(lock_lost), 0);
        check("relock_fail1", 32'(relock_req), 0);

        wait_valid(n);
        check("lost_fail2",   32'(lock_lost), 1);
        check("relock_fail2", 32'(relock_req), 1);
        tick();
        check("relock_pulse", 32'(relock_req), 0);
        check("lost_sticky",  32'(lock_lost), 1);

        wait_valid(n);
        check("period_fail3", 32'(n), 21);
        check("relock_fail3", 32'(relock_req), 0);
        check("lost_fail3",   32'(lock_lost), 1);

        // Drop lock mid-window: back to IDLE, flags cleared, no measurement
        repeat (8) tick();
        locked_in = 1'b0;
        tick();
        check("drop_lost_clr", 32'(lock_lost), 0);
        check("drop_ok_clr",   32'(freq_ok), 0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (meas_valid) seen = 1'b1;
        end
        check("drop_no_valid", 32'(seen), 0);

        dco_half  = 1.0;
        locked_in = 1'b1;
        tick();
        wait_valid(n);
        check("relock_latency", 32'(n), 22);
        check("cnt_relock_rng", in_rng(freq_cnt, 159, 161), 1);
        check("ok_relock",      32'(freq_ok), 1);

        // Fail, pass, fail: counter clears on the pass so no loss of lock
        dco_half = 0.952;
        wait_valid(n);
        check("fpf_ok1", 32'(freq_ok), 0);
        dco_half = 1.0;
        wait_valid(n);
        check("fpf_ok2", 32'(freq_ok), 1);
        dco_half = 0.952;
        wait_valid(n);
        check("fpf_ok3",     32'(freq_ok), 0);
        check("fpf_lost",    32'(lock_lost), 0);
        check("fpf_relock",  32'(relock_req), 0);

        // Stop DCO, then reset in SETTLE; restart with DCO still stopped
        dco_half = 1.0;
        wait_valid(n);
        check("pre_stop_ok", 32'(freq_ok), 1);
        dco_run = 1'b0;
        repeat (19) tick();
        check("settle_no_valid", 32'(meas_valid), 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_freq_cnt", 32'(freq_cnt),   0);
        check("mid_rst_freq_ok",  32'(freq_ok),    0);
        check("mid_rst_valid",    32'(meas_valid), 0);
        check("mid_rst_lost",     32'(lock_lost),  0);
        check("mid_rst_relock",   32'(relock_req), 0);
        tick();
        rst_n = 1'b1;
        tick();
        wait_valid(n);
        check("stopped_latency", 32'(n), 22);
        check("stopped_cnt",     32'(freq_cnt), 0);
        check("stopped_ok",      32'(freq_ok), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Frequency-based lock monitor downstream of the all-digital PLL. It consumes the PLL's DCO output clock and `locked` flag. Once lock is reported, it repeatedly counts DCO cycles over a fixed window of reference-clock cycles and checks the count against the expected multiplication ratio. It flags loss of lock after consecutive out-of-tolerance windows and issues a one-cycle relock request back to PLL control.

## Interface
- `WIN_CYC`, 16: measurement window length in `clk` cycles.
- `MULT`, 10: expected DCO/ref ratio (PLL divider is /10).
- `TOL`, 4: allowed absolute count error, in DCO cycles.
- `SETTLE_CYC`, 4: `clk` cycles waited after window close before sampling; must be ≥ 3.
- `FAIL_LIMIT`, 2: consecutive failing windows that trigger loss of lock; range 1–15.
- `CNT_W`, 10: DCO counter width; must satisfy 2^CNT_W − 1 > MULT·WIN_CYC + TOL.
- `clk` input 1: reference clock; all control logic lives here.
- `rst_n` input 1: asynchronous active-low reset; resets both clock domains.
- `dco_clk` input 1: PLL DCO output (`clk_out`); may be stopped.
- `locked_in` input 1: PLL `locked`; synchronous to `clk`.
- `freq_cnt` output CNT_W: last sampled DCO count.
- `meas_valid` output 1: one-cycle pulse when `freq_cnt`/`freq_ok` update.
- `freq_ok` output 1: last window within tolerance.
- `lock_lost` output 1: sticky loss-of-lock flag.
- `relock_req` output 1: one-cycle pulse when `lock_lost` sets.

## Operation
- States are IDLE, ARM, WINDOW, SETTLE and EVAL.
- IDLE:
  - `win_en` = 0; fail counter, `lock_lost` and `freq_ok` are cleared.
  - Moves to ARM when `locked_in` = 1.
- ARM: lasts 1 cycle, then goes to WINDOW.
- WINDOW:
  - `win_en` = 1 for exactly `WIN_CYC` cycles.
  - A cycle counter (clog2(WIN_CYC)+1 bits) is cleared on entry.
- SETTLE: `win_en` = 0 for `SETTLE_CYC` cycles, then goes to EVAL.
- EVAL:
  - Samples the DCO counter. The value is quasi-static, so it needs no synchronizer.
  - Computes err = |cnt − MULT·WIN_CYC| at width CNT_W+1 (unsigned difference, larger minus smaller).
  - Sets `freq_ok` = (err ≤ TOL) and returns to ARM.
- `locked_in` = 0 in any state moves to IDLE on the next edge. Any in-flight measurement is discarded, with no `meas_valid`.
- DCO domain:
  - `win_en` passes through a 2-flop synchronizer clocked by `dco_clk` to give `win_s`; a 3rd flop gives `win_d`.
  - On `win_s & ~win_d` the counter loads 1. While `win_s` = 1 it increments. Otherwise it holds.
  - The counter saturates at all-ones.
  - Synchronizer latency is equal on both window edges, so it cancels.
- Fail logic, in EVAL:
  - `freq_ok` = 1 clears the fail counter.
  - Otherwise the fail counter increments and saturates at `FAIL_LIMIT`.
  - When the fail counter reaches `FAIL_LIMIT` and `lock_lost` = 0: `lock_lost` ← 1 and `relock_req` pulses.
- `lock_lost` clears only on reset or `locked_in` = 0. Measurement continues while it is set.
- A stopped `dco_clk` leaves the counter frozen. If it never restarts, the count is stale (0 after reset) and the window fails.
- Reset mid-operation: all state returns to reset values immediately, in both domains.

## Timing
- Reset values:
  - `freq_cnt` = 0, `meas_valid` = 0, `freq_ok` = 0, `lock_lost` = 0, `relock_req` = 0.
  - State = IDLE.
  - DCO counter = 0.
  - `win_s` = `win_d` = 0.
- First `meas_valid` comes 1 + WIN_CYC + SETTLE_CYC + 1 cycles after the first edge with `locked_in` = 1, which is 22 cycles at defaults.
- The measurement period is 1 + WIN_CYC + SETTLE_CYC + 1 = 22 cycles.
- Outputs are registered and update on the edge leaving EVAL:
  - `meas_valid` and `relock_req` are high for exactly 1 cycle.
  - `freq_cnt` and `freq_ok` hold until the next EVAL.
- `locked_in` falling in the same cycle as EVAL takes priority: there is no update and no pulse.

## Configuration
- `PLL_LOCK_MON_HIST_EN` defined:
  - Adds outputs `cnt_min` and `cnt_max`, each CNT_W bits wide.
  - They track the min and max of `freq_cnt` over all EVALs since entering ARM from IDLE.
  - Reset and IDLE values are `cnt_min` = all-ones and `cnt_max` = 0.
  - Both update on the same edge as `meas_valid`.
- Undefined: the ports and logic are absent. Core behaviour is identical.

## Test plan
- DCO at exactly 10× `clk`, `locked_in` = 1 → `meas_valid` at cycle 22 and every 22 thereafter; `freq_cnt` = 160 (±1 from sync phase), `freq_ok` = 1, `lock_lost` = 0.
- DCO at 10.25× → `freq_cnt` ≈ 164, `freq_ok` = 1. DCO at 10.5× → `freq_cnt` ≈ 168, `freq_ok` = 0 and the fail counter increments.
- Two consecutive failing windows → `lock_lost` = 1 at the 2nd `meas_valid`, `relock_req` high for 1 cycle. A 3rd failing window produces no further `relock_req`.
- Fail, pass, fail sequence → `lock_lost` stays 0, because the fail counter clears on the pass.
- `locked_in` dropped mid-WINDOW → IDLE next cycle, no `meas_valid`, `lock_lost` = 0. On reassert, the next `meas_valid` arrives 22 cycles later.
- `dco_clk` stopped after lock, then `rst_n` pulsed low mid-SETTLE → all outputs 0 immediately. After restart with `locked_in` = 1 and DCO still stopped → `freq_cnt` = 0, `freq_ok` = 0.
